// File: rtl/iddmm_final_sub.sv
// IDDMM final stage: compares A (a-RAM plus overflow bit) against M, streams A-M or A
// low word first, then zeroes the a-RAM for the next task.
module iddmm_final_sub #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              task_req,
   output logic              task_end,
   output logic [K-1:0]      res,
   output logic              res_val,
   output logic              clra_mem,
   output logic              clra_wren,
   output logic [ADDR_W-1:0] clra_addr,
   input  logic [K-1:0]      aj,
   input  logic [K-1:0]      an,
   input  logic [K-1:0]      mj,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_m
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMP, S_CWAIT, S_OUT, S_OWAIT, S_ODRAIN, S_CLR, S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] cnt;
   logic              req_q;
   logic              start;
   logic              cmp_dv, out_dv;
   logic              brw, sub_flag;
   logic              b_nx;
   logic [K-1:0]      diff;
   logic              an_unused;

   assign an_unused = ^an[K-1:1];
   assign start     = task_req & ~req_q & (state == S_IDLE);

   // borrow chain shared by compare and subtract passes
   assign b_nx = ({1'b0, aj} < ({1'b0, mj} + {{K{1'b0}}, brw}));
   assign diff = aj - mj - {{(K-1){1'b0}}, brw};

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start)        state_nx = S_CMP;
         S_CMP:    if (cnt == LAST)  state_nx = S_CWAIT;
         S_CWAIT:                    state_nx = S_OUT;
         S_OUT:    if (cnt == LAST)  state_nx = S_OWAIT;
         S_OWAIT:                    state_nx = S_ODRAIN;
         S_ODRAIN:                   state_nx = S_CLR;
         S_CLR:    if (cnt == LAST)  state_nx = S_DONE;
         S_DONE:                     state_nx = S_IDLE;
         default:                    state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         req_q <= 1'b0;
      end else begin
         state <= state_nx;
         req_q <= task_req;
         if (state_nx != state)
            cnt <= '0;
         else if (state == S_CMP || state == S_OUT || state == S_CLR)
            cnt <= cnt + ADDR_W'(1);
      end
   end

   // RAM reads return one cycle after the address; these flag the returning word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_dv   <= 1'b0;
         out_dv   <= 1'b0;
         brw      <= 1'b0;
         sub_flag <= 1'b0;
         res      <= '0;
         res_val  <= 1'b0;
      end else begin
         cmp_dv  <= (state == S_CMP);
         out_dv  <= (state == S_OUT);
         res_val <= out_dv;
         res     <= out_dv ? (sub_flag ? diff : aj) : '0;
         if (start) begin
            brw      <= 1'b0;
            sub_flag <= 1'b0;
         end else if (cmp_dv) begin
            if (state == S_CWAIT) begin
               // last pair: A >= M when overflow set or no final borrow
               sub_flag <= an[0] | ~b_nx;
               brw      <= 1'b0;
            end else begin
               brw <= b_nx;
            end
         end else if (out_dv) begin
            brw <= sub_flag & b_nx;
         end
      end
   end

   assign addr_a    = (state == S_CMP || state == S_OUT) ? cnt : '0;
   assign addr_m    = addr_a;
   assign clra_mem  = (state == S_CLR);
   assign clra_wren = (state == S_CLR);
   assign clra_addr = (state == S_CLR) ? cnt : '0;
   assign task_end  = (state == S_DONE);

endmodule

// File: tb/tb_iddmm_final_sub.sv
// Bench for iddmm_final_sub: registered-read RAM models plus an integer reference model.
module tb_iddmm_final_sub;
   localparam int K  = 8;
   localparam int N  = 4;
   localparam int AW = 2;

   logic          clk = 1'b0, rst_n = 1'b0, task_req = 1'b0;
   logic          task_end, res_val, clra_mem, clra_wren;
   logic [K-1:0]  res, aj, mj, an;
   logic [AW-1:0] clra_addr, addr_a, addr_m;
   logic [K-1:0]  a_mem [N];
   logic [K-1:0]  m_mem [N];
   logic [K-1:0]  ld_a  [N];
   logic          load = 1'b0;
   int            tests = 0, fails = 0;

   always #5 clk = ~clk;

   iddmm_final_sub #(.K(K), .N(N), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .task_req(task_req), .task_end(task_end),
      .res(res), .res_val(res_val), .clra_mem(clra_mem), .clra_wren(clra_wren),
      .clra_addr(clra_addr), .aj(aj), .an(an), .mj(mj),
      .addr_a(addr_a), .addr_m(addr_m)
   );

   always @(posedge clk) begin
      aj <= a_mem[addr_a];
      mj <= m_mem[addr_m];
      if (load) begin
         for (int i = 0; i < N; i++) a_mem[i] <= ld_a[i];
      end else if (clra_wren) begin
         a_mem[clra_addr] <= '0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs_now();
      return 64'({task_end, res, res_val, clra_mem, clra_wren, clra_addr, addr_a, addr_m});
   endfunction

   task automatic load_ops(input logic [31:0] a_val, input logic an0, input logic [31:0] m_val);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         ld_a[i]  = a_val[K*i +: K];
         m_mem[i] = m_val[K*i +: K];
      end
      an   = {7'b0, an0};
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   // Runs one task and leaves task_req high on return.
   task automatic run_task(input string tag, input logic [31:0] a_val, input logic an0,
                           input logic [31:0] m_val);
      logic [63:0] A, M, R, got, mem;
      int nres, gaps, ends, lat, nclr, bad;
      logic prev;
      A = {31'b0, an0, a_val};
      M = {32'b0, m_val};
      R = (A >= M) ? ((A - M) & 64'hFFFF_FFFF) : A;
      got = '0; nres = 0; gaps = 0; ends = 0; lat = -1; nclr = 0; bad = 0; prev = 1'b0;
      load_ops(a_val, an0, m_val);
      task_req = 1'b1;
      for (int cyc = 0; cyc < 3*N + 12; cyc++) begin
         @(negedge clk);
         if (res_val) begin
            if (nres > 0 && !prev) gaps++;
            if (nres < N) got[K*nres +: K] = res;
            nres++;
         end
         prev = res_val;
         if (clra_wren) begin
            if (!clra_mem || clra_addr != AW'(nclr) || nres != N) bad++;
            nclr++;
         end
         if (clra_mem != clra_wren || addr_a != addr_m) bad++;
         if (task_end) begin
            if (nclr != N) bad++;
            if (ends == 0) lat = cyc;
            ends++;
         end
      end
      mem = '0;
      for (int i = 0; i < N; i++) mem[K*i +: K] = a_mem[i];
      check({tag, " result"}, got, R);
      check({tag, " res_val count"}, 64'(nres), 64'(N));
      check({tag, " res_val gaps"}, 64'(gaps), 64'd0);
      check({tag, " clear writes"}, 64'(nclr), 64'(N));
      check({tag, " sequencing"}, 64'(bad), 64'd0);
      check({tag, " task_end pulses"}, 64'(ends), 64'd1);
      check({tag, " latency in range"}, 64'(lat >= 3*N && lat <= 3*N + 8), 64'd1);
      check({tag, " a-ram cleared"}, mem, 64'd0);
   endtask

   initial begin
      logic [31:0] mv;
      logic [63:0] av;
      int seen, act;
      an = '0;
      for (int i = 0; i < N; i++) begin a_mem[i] = '0; m_mem[i] = '0; ld_a[i] = '0; end

      #1;
      check("reset outputs", outs_now(), 64'd0);
      repeat (2) @(negedge clk);
      check("reset outputs held", outs_now(), 64'd0);
      rst_n = 1'b1;

      run_task("A<M", 32'h0000_0010, 1'b0, 32'h0000_0020);
      task_req = 1'b0;
      run_task("borrow chain", 32'h0100_0005, 1'b0, 32'h00FF_FFFF);
      task_req = 1'b0;
      run_task("overflow bit", 32'h0000_0000, 1'b1, 32'h7FFF_FFFF);
      task_req = 1'b0;
      run_task("A==M", 32'h1234_5678, 1'b0, 32'h1234_5678);

      // task_req kept high after completion must not retrigger
      act = 0;
      for (int c = 0; c < 3*N + 8; c++) begin
         @(negedge clk);
         if (res_val || clra_wren || task_end || addr_a != '0) act++;
      end
      check("held req no restart", 64'(act), 64'd0);
      task_req = 1'b0;
      run_task("after held req", 32'h0000_00FF, 1'b0, 32'h0000_0080);
      task_req = 1'b0;

      // reset during the output phase
      load_ops(32'h0100_0005, 1'b0, 32'h00FF_FFFF);
      task_req = 1'b1;
      seen = 0;
      for (int c = 0; c < 3*N + 8 && seen == 0; c++) begin
         @(negedge clk);
         if (res_val) seen = 1;
      end
      check("reached OUT before reset", 64'(seen), 64'd1);
      rst_n = 1'b0;
      task_req = 1'b0;
      #1;
      check("mid-op reset outputs", outs_now(), 64'd0);
      act = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (outs_now() != 64'd0) act++;
      end
      check("outputs quiet in reset", 64'(act), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("no task_end after reset", 64'(task_end), 64'd0);
      run_task("after reset", 32'h0100_0005, 1'b0, 32'h00FF_FFFF);
      task_req = 1'b0;

      // random operands honouring A < 2M
      for (int t = 0; t < 6; t++) begin
         mv = $urandom;
         if (mv < 32'd2) mv = 32'd2;
         av = {$urandom, $urandom};
         av = av % (64'(mv) * 2);
         run_task($sformatf("random %0d", t), av[31:0], av[32], mv);
         task_req = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
